// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg : shared definitions for the memory access controller.
//   - access width encodings (byte / halfword / word)
//   - controller state enumeration
//   - access_ok(): legality of an access for a given address tail and width
// Optional feature macro: MEM_HALFWORD_EN (makes halfword accesses legal).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] WIDTH_B = 2'b01;
    localparam logic [1:0] WIDTH_H = 2'b10;
    localparam logic [1:0] WIDTH_W = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Bytes may sit on any lane, words must be word aligned, halfwords (when
    // enabled) must be halfword aligned; every other encoding is an error.
    function automatic logic access_ok(input logic [1:0] tail, input logic [1:0] width);
        logic ok;
        case (width)
            WIDTH_B: ok = 1'b1;
            WIDTH_W: ok = (tail == 2'b00);
            WIDTH_H: begin
`ifdef MEM_HALFWORD_EN
                ok = (tail[0] == 1'b0);
`else
                ok = 1'b0;
`endif
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if : core request/response bus plus memory bus of the
// memory access controller.
//   slave  modport : the controller (mem_access_ctrl)
//   master modport : the environment (core + memory) driving the controller
// Core side  : req_valid/req_ready/req_we/req_addr/req_width/req_zext/req_wdata,
//              resp_valid/resp_rdata/resp_err
// Memory side: mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int MEM_AW = 30
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [1:0]        req_width;
    logic              req_zext;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req_valid, req_we, req_addr, req_width, req_zext, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_width, req_zext, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_access_ctrl_lane.sv
// -----------------------------------------------------------------------------
// mem_lane : combinational lane handling for the memory access controller.
// Ports:
//   i_word   - memory word (fetched data)
//   i_tail   - byte address bits [1:0]
//   i_width  - access width encoding
//   i_zext   - 1 = zero-extend loads, 0 = sign-extend
//   i_wdata  - store data (byte in [7:0], halfword in [15:0])
//   o_load   - selected lane, extended to 32 bits (word passes unchanged)
//   o_merge  - i_word with the addressed lane replaced by store data
// Optional feature macro: MEM_HALFWORD_EN (adds 16-bit lane handling).
// -----------------------------------------------------------------------------
module mem_lane
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_tail,
    input  logic [1:0]  i_width,
    input  logic        i_zext,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the word.
    always_comb begin
        case (i_tail)
            2'b00:   w_byte = i_word[7:0];
            2'b01:   w_byte = i_word[15:8];
            2'b10:   w_byte = i_word[23:16];
            2'b11:   w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_tail[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
    end

    // Extend the selected lane for loads and splice store data for RMW.
    always_comb begin
        o_load  = i_word;
        o_merge = i_word;
        case (i_width)
            WIDTH_B: begin
                o_load = {{24{~i_zext & w_byte[7]}}, w_byte};
                case (i_tail)
                    2'b00:   o_merge[7:0]   = i_wdata[7:0];
                    2'b01:   o_merge[15:8]  = i_wdata[7:0];
                    2'b10:   o_merge[23:16] = i_wdata[7:0];
                    2'b11:   o_merge[31:24] = i_wdata[7:0];
                    default: o_merge        = i_word;
                endcase
            end
`ifdef MEM_HALFWORD_EN
            WIDTH_H: begin
                o_load = {{16{~i_zext & w_half[15]}}, w_half};
                if (i_tail[1]) begin
                    o_merge[31:16] = i_wdata[15:0];
                end else begin
                    o_merge[15:0] = i_wdata[15:0];
                end
            end
`endif
            default: begin
                o_load  = i_word;
                o_merge = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl : multi-cycle load/store sequencer between the core and a
// 32-bit word-addressed data memory. One access at a time.
//   loads           : read word, extract + extend lane, respond
//   sub-word stores : read word, merge lane, write word back, respond
//   word stores     : write word, respond
//   illegal access  : error response, no memory cycle
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset
//   io_bus - mem_access_ctrl_if.slave (core request/response + memory bus)
// Parameter MEM_AW: memory word-address width (word addr = req_addr[MEM_AW+1:2]).
// Optional feature macro: MEM_HALFWORD_EN (halfword loads/stores).
// All interface outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_AW = 30
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  io_bus
);

    // captured request and internal state
    state_t            r_state, w_nxt_state;
    logic              r_we, w_nxt_we;
    logic [1:0]        r_tail, w_nxt_tail;
    logic [1:0]        r_width, w_nxt_width;
    logic              r_zext, w_nxt_zext;
    logic [31:0]       r_wdata, w_nxt_wdata;
    logic [31:0]       r_fetch, w_nxt_fetch;
    // set for the first RESP cycle of a load, where the lane is formatted
    logic              r_fmt, w_nxt_fmt;

    // registered outputs
    logic              r_req_ready, w_nxt_req_ready;
    logic              r_resp_valid, w_nxt_resp_valid;
    logic [31:0]       r_resp_rdata, w_nxt_resp_rdata;
    logic              r_resp_err, w_nxt_resp_err;
    logic              r_mem_req, w_nxt_mem_req;
    logic              r_mem_we, w_nxt_mem_we;
    logic [MEM_AW-1:0] r_mem_addr, w_nxt_mem_addr;
    logic [31:0]       r_mem_wdata, w_nxt_mem_wdata;

    logic [31:0]       w_lane_word;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;

    // RMW merges the word arriving from memory; load formatting uses the latched copy.
    assign w_lane_word = (r_state == RD) ? io_bus.mem_rdata : r_fetch;

    mem_lane u_lane (
        .i_word  (w_lane_word),
        .i_tail  (r_tail),
        .i_width (r_width),
        .i_zext  (r_zext),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_merge (w_merge)
    );

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_we         = r_we;
        w_nxt_tail       = r_tail;
        w_nxt_width      = r_width;
        w_nxt_zext       = r_zext;
        w_nxt_wdata      = r_wdata;
        w_nxt_fetch      = r_fetch;
        w_nxt_fmt        = r_fmt;
        w_nxt_req_ready  = r_req_ready;
        w_nxt_resp_valid = r_resp_valid;
        w_nxt_resp_rdata = r_resp_rdata;
        w_nxt_resp_err   = r_resp_err;
        w_nxt_mem_req    = r_mem_req;
        w_nxt_mem_we     = r_mem_we;
        w_nxt_mem_addr   = r_mem_addr;
        w_nxt_mem_wdata  = r_mem_wdata;

        case (r_state)
            IDLE: begin
                w_nxt_resp_valid = 1'b0;
                w_nxt_resp_err   = 1'b0;
                w_nxt_resp_rdata = 32'h0000_0000;
                if (io_bus.req_valid && r_req_ready) begin
                    w_nxt_we        = io_bus.req_we;
                    w_nxt_tail      = io_bus.req_addr[1:0];
                    w_nxt_width     = io_bus.req_width;
                    w_nxt_zext      = io_bus.req_zext;
                    w_nxt_wdata     = io_bus.req_wdata;
                    w_nxt_fmt       = 1'b0;
                    w_nxt_req_ready = 1'b0;
                    if (!access_ok(io_bus.req_addr[1:0], io_bus.req_width)) begin
                        // error response goes out in the very next cycle
                        w_nxt_state      = ERR;
                        w_nxt_resp_valid = 1'b1;
                        w_nxt_resp_err   = 1'b1;
                    end else if (io_bus.req_we && (io_bus.req_width == WIDTH_W)) begin
                        w_nxt_state     = WR;
                        w_nxt_mem_req   = 1'b1;
                        w_nxt_mem_we    = 1'b1;
                        w_nxt_mem_addr  = io_bus.req_addr[MEM_AW+1:2];
                        w_nxt_mem_wdata = io_bus.req_wdata;
                    end else begin
                        w_nxt_state    = RD;
                        w_nxt_mem_req  = 1'b1;
                        w_nxt_mem_we   = 1'b0;
                        w_nxt_mem_addr = io_bus.req_addr[MEM_AW+1:2];
                    end
                end else begin
                    w_nxt_req_ready = 1'b1;
                end
            end
            RD: begin
                if (io_bus.mem_ack) begin
                    if (r_we) begin
                        // sub-word store: the write is issued straight after the read
                        w_nxt_state     = WR;
                        w_nxt_mem_req   = 1'b1;
                        w_nxt_mem_we    = 1'b1;
                        w_nxt_mem_wdata = w_merge;
                    end else begin
                        w_nxt_state   = RESP;
                        w_nxt_mem_req = 1'b0;
                        w_nxt_fetch   = io_bus.mem_rdata;
                        w_nxt_fmt     = 1'b1;
                    end
                end else begin
                    w_nxt_state = RD;
                end
            end
            WR: begin
                if (io_bus.mem_ack) begin
                    w_nxt_state      = RESP;
                    w_nxt_mem_req    = 1'b0;
                    w_nxt_mem_we     = 1'b0;
                    w_nxt_resp_valid = 1'b1;
                    w_nxt_resp_err   = 1'b0;
                    w_nxt_resp_rdata = 32'h0000_0000;
                end else begin
                    w_nxt_state = WR;
                end
            end
            RESP: begin
                if (r_fmt) begin
                    // load: present the formatted lane as a one-cycle pulse
                    w_nxt_fmt        = 1'b0;
                    w_nxt_resp_valid = 1'b1;
                    w_nxt_resp_err   = 1'b0;
                    w_nxt_resp_rdata = w_load;
                end else begin
                    w_nxt_state      = IDLE;
                    w_nxt_resp_valid = 1'b0;
                    w_nxt_resp_err   = 1'b0;
                    w_nxt_resp_rdata = 32'h0000_0000;
                    w_nxt_req_ready  = 1'b1;
                end
            end
            ERR: begin
                w_nxt_state      = IDLE;
                w_nxt_resp_valid = 1'b0;
                w_nxt_resp_err   = 1'b0;
                w_nxt_resp_rdata = 32'h0000_0000;
                w_nxt_req_ready  = 1'b1;
            end
            default: begin
                w_nxt_state      = IDLE;
                w_nxt_fmt        = 1'b0;
                w_nxt_req_ready  = 1'b1;
                w_nxt_resp_valid = 1'b0;
                w_nxt_resp_err   = 1'b0;
                w_nxt_resp_rdata = 32'h0000_0000;
                w_nxt_mem_req    = 1'b0;
                w_nxt_mem_we     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_tail       <= 2'b00;
            r_width      <= 2'b00;
            r_zext       <= 1'b0;
            r_wdata      <= 32'h0000_0000;
            r_fetch      <= 32'h0000_0000;
            r_fmt        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {MEM_AW{1'b0}};
            r_mem_wdata  <= 32'h0000_0000;
        end else begin
            r_state      <= w_nxt_state;
            r_we         <= w_nxt_we;
            r_tail       <= w_nxt_tail;
            r_width      <= w_nxt_width;
            r_zext       <= w_nxt_zext;
            r_wdata      <= w_nxt_wdata;
            r_fetch      <= w_nxt_fetch;
            r_fmt        <= w_nxt_fmt;
            r_req_ready  <= w_nxt_req_ready;
            r_resp_valid <= w_nxt_resp_valid;
            r_resp_rdata <= w_nxt_resp_rdata;
            r_resp_err   <= w_nxt_resp_err;
            r_mem_req    <= w_nxt_mem_req;
            r_mem_we     <= w_nxt_mem_we;
            r_mem_addr   <= w_nxt_mem_addr;
            r_mem_wdata  <= w_nxt_mem_wdata;
        end
    end

    assign io_bus.req_ready  = r_req_ready;
    assign io_bus.resp_valid = r_resp_valid;
    assign io_bus.resp_rdata = r_resp_rdata;
    assign io_bus.resp_err   = r_resp_err;
    assign io_bus.mem_req    = r_mem_req;
    assign io_bus.mem_we     = r_mem_we;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl : self-checking bench for mem_access_ctrl.
// A behavioural memory answers requests after a programmable number of wait
// cycles; each access is predicted from the byte/lane rules (arithmetic on the
// bench's own memory image) and the response, latency and memory traffic are
// compared. Honours MEM_HALFWORD_EN.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int AW = 30;
`ifdef MEM_HALFWORD_EN
    localparam bit HW = 1'b1;
`else
    localparam bit HW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.MEM_AW(AW)) bus ();

    mem_access_ctrl #(.MEM_AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [int];
    int          mem_waits = 0;
    int          wait_cnt  = 0;
    int          n_rd      = 0;
    int          n_wr      = 0;
    logic        holding   = 1'b0;
    logic [31:0] hold_addr;
    logic        hold_we;
    logic [31:0] hold_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_peek(input int a);
        if (mem.exists(a)) return mem[a];
        return 32'h5A00_0000 ^ 32'(a);
    endfunction

    // Behavioural memory: acks after mem_waits cycles, checks the request is held.
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            if (holding) begin
                chk("mem_hold_addr", {2'b00, bus.mem_addr}, hold_addr);
                chk("mem_hold_we", {31'd0, bus.mem_we}, {31'd0, hold_we});
                chk("mem_hold_wdata", bus.mem_wdata, hold_wdata);
            end
            if (wait_cnt >= mem_waits) begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) begin
                    mem[int'(bus.mem_addr)] = bus.mem_wdata;
                    bus.mem_rdata = $urandom;
                    n_wr++;
                end else begin
                    bus.mem_rdata = mem_peek(int'(bus.mem_addr));
                    n_rd++;
                end
                wait_cnt = 0;
                holding  = 1'b0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                wait_cnt++;
                holding    = 1'b1;
                hold_addr  = {2'b00, bus.mem_addr};
                hold_we    = bus.mem_we;
                hold_wdata = bus.mem_wdata;
            end
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            wait_cnt      = 0;
            holding       = 1'b0;
        end
    end

    task automatic chk_reset(input string p);
        chk({p, "_req_ready"},  {31'd0, bus.req_ready},  32'h1);
        chk({p, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'h0);
        chk({p, "_resp_err"},   {31'd0, bus.resp_err},   32'h0);
        chk({p, "_resp_rdata"}, bus.resp_rdata,          32'h0);
        chk({p, "_mem_req"},    {31'd0, bus.mem_req},    32'h0);
        chk({p, "_mem_we"},     {31'd0, bus.mem_we},     32'h0);
        chk({p, "_mem_addr"},   {2'b00, bus.mem_addr},   32'h0);
        chk({p, "_mem_wdata"},  bus.mem_wdata,           32'h0);
    endtask

    // One complete access: predict, drive, wait for the response, compare.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] width, input logic zext,
                          input logic [31:0] wdata, input int waits,
                          output logic [31:0] got);
        int          wa;
        int          tail;
        int          sh;
        bit          legal;
        logic [31:0] old_w, new_w, exp_rd, lane, mask;
        int          exp_lat, exp_nrd, exp_nwr, rd0, wr0, k;

        wa    = int'(addr >> 2);
        tail  = int'(addr & 32'h3);
        old_w = mem_peek(wa);
        new_w = old_w;
        exp_rd = 32'h0;
        legal = (width == 2'b01) || (width == 2'b11 && tail == 0) ||
                (HW && width == 2'b10 && (tail % 2) == 0);
        if (!legal) begin
            exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
        end else if (width == 2'b11) begin
            if (we) begin
                new_w = wdata; exp_lat = 2 + waits; exp_nrd = 0; exp_nwr = 1;
            end else begin
                exp_rd = old_w; exp_lat = 3 + waits; exp_nrd = 1; exp_nwr = 0;
            end
        end else begin
            sh   = (width == 2'b01) ? 8 * tail : 16 * (tail / 2);
            mask = (width == 2'b01) ? 32'hFF : 32'hFFFF;
            if (we) begin
                new_w = (old_w & ~(mask << sh)) | ((wdata & mask) << sh);
                exp_lat = 3 + 2 * waits; exp_nrd = 1; exp_nwr = 1;
            end else begin
                lane = (old_w >> sh) & mask;
                if (!zext && ((lane & ((mask >> 1) + 32'h1)) != 32'h0)) lane = lane | ~mask;
                exp_rd = lane; exp_lat = 3 + waits; exp_nrd = 1; exp_nwr = 0;
            end
        end

        mem_waits = waits;
        rd0 = n_rd;
        wr0 = n_wr;
        @(negedge clk);
        chk({tag, "_ready_before"}, {31'd0, bus.req_ready}, 32'h1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_width = width; bus.req_zext = zext; bus.req_wdata = wdata;
        @(negedge clk);
        // garbage requests while busy must be ignored
        bus.req_valid = 1'b1; bus.req_we = $urandom; bus.req_addr = $urandom;
        bus.req_width = $urandom; bus.req_zext = $urandom; bus.req_wdata = $urandom;
        k = 1;
        while (bus.resp_valid !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        bus.req_valid = 1'b0;
        got = bus.resp_rdata;
        chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
        chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'h1);
        chk({tag, "_resp_err"}, {31'd0, bus.resp_err}, {31'd0, !legal});
        chk({tag, "_resp_rdata"}, bus.resp_rdata, exp_rd);
        chk({tag, "_ready_during"}, {31'd0, bus.req_ready}, 32'h0);
        @(negedge clk);
        chk({tag, "_pulse_end"}, {31'd0, bus.resp_valid}, 32'h0);
        chk({tag, "_ready_after"}, {31'd0, bus.req_ready}, 32'h1);
        chk({tag, "_n_reads"}, 32'(n_rd - rd0), 32'(exp_nrd));
        chk({tag, "_n_writes"}, 32'(n_wr - wr0), 32'(exp_nwr));
        chk({tag, "_mem_word"}, mem_peek(wa), new_w);
    endtask

    initial begin : main
        logic [31:0] r;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
        bus.req_width = 2'b00; bus.req_zext = 1'b0; bus.req_wdata = 32'h0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        mem[32'h40] = 32'h80FF7F01;
        access("ld_b_s3", 1'b0, 32'h103, 2'b01, 1'b0, 32'h0, 0, r);
        chk("tp_ld_b_s3", r, 32'hFFFFFF80);
        access("ld_b_z1", 1'b0, 32'h101, 2'b01, 1'b1, 32'h0, 0, r);
        chk("tp_ld_b_z1", r, 32'h0000007F);
        access("ld_b_s2", 1'b0, 32'h102, 2'b01, 1'b0, 32'h0, 0, r);
        chk("tp_ld_b_s2", r, 32'hFFFFFFFF);
        access("ld_w", 1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 1, r);

        mem[32'h80] = 32'h11223344;
        access("st_b_rmw", 1'b1, 32'h202, 2'b01, 1'b0, 32'h000000AB, 0, r);
        chk("tp_st_b_rmw", mem_peek(32'h80), 32'h11AB3344);
        for (int t = 0; t < 4; t++) begin
            access("st_b_lane", 1'b1, 32'h210 + 32'(t), 2'b01, 1'b0, 32'h0000C0 + 32'(t), 1, r);
        end

        access("st_w_wait2", 1'b1, 32'h40, 2'b11, 1'b0, 32'hDEADBEEF, 2, r);
        chk("tp_st_w_wait2", mem_peek(32'h10), 32'hDEADBEEF);

        access("ld_w_misal", 1'b0, 32'h102, 2'b11, 1'b0, 32'h0, 0, r);
        access("width00", 1'b1, 32'h104, 2'b00, 1'b0, 32'h12345678, 0, r);

        mem[32'h50] = 32'h12348000;
        access("ld_h", 1'b0, 32'h140, 2'b10, 1'b0, 32'h0, 0, r);
`ifdef MEM_HALFWORD_EN
        chk("tp_ld_h", r, 32'hFFFF8000);
`endif
        access("st_h", 1'b1, 32'h142, 2'b10, 1'b0, 32'h0000BEEF, 1, r);

        // reset while a read is waiting on the memory
        mem_waits = 6;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h104;
        bus.req_width = 2'b01; bus.req_zext = 1'b0; bus.req_wdata = 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_mem_req", {31'd0, bus.mem_req}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("rst_mid");
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("rst_no_resp", {31'd0, bus.resp_valid}, 32'h0);
        end
        access("after_rst", 1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 0, r);

        for (int t = 0; t < 40; t++) begin
            access("rnd", 1'($urandom), 32'h300 + 32'($urandom_range(0, 31)),
                   2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                   int'($urandom_range(0, 2)), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
